// File: rtl/cache_line_mem_engine.sv
// Memory-side engine for a write-back/write-allocate cache: optionally writes the dirty victim
// line to byte-wide RAM, then reads and assembles the new line and pulses done.
module cache_line_mem_engine #(
  parameter int ADDRESS_WIDTH     = 16,
  parameter int WORD_OFFSET_WIDTH = 2,
  parameter int RAM_RD_LATENCY    = 2,
  localparam int OFS_W      = WORD_OFFSET_WIDTH + 2,
  localparam int LINE_BYTES = 4 << WORD_OFFSET_WIDTH,
  localparam int LINE_W     = ADDRESS_WIDTH - OFS_W,
  localparam int LINE_BITS  = 8 * LINE_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wb,
  input  logic [LINE_W-1:0]        req_wb_line,
  input  logic [LINE_BITS-1:0]     req_wb_data,
  input  logic [LINE_W-1:0]        req_fill_line,
  output logic [LINE_BITS-1:0]     fill_data,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_rd,
  output logic                     ram_wr,
  output logic [7:0]               ram_wdata,
  input  logic [7:0]               ram_rdata
);

  localparam logic [OFS_W-1:0] LAST_IDX = OFS_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, WB, RD, DRAIN, DONE} state_t;

  state_t                            state_r, state_s;
  logic [OFS_W-1:0]                  cnt_r, cnt_s;
  logic [LINE_W-1:0]                 wb_line_r, fill_line_r;
  logic [LINE_BITS-1:0]              wb_data_r, fill_data_r;
  logic                              req_ready_r, done_r, ram_rd_r, ram_wr_r;
  logic [ADDRESS_WIDTH-1:0]          ram_address_r, addr_s;
  logic [7:0]                        ram_wdata_r, wdata_s;
  logic                              rd_s, wr_s, done_s, accept_s, last_emerge_s;
  // One (valid, byte index) entry per issued read, aligned with ram_rdata at the tail.
  logic [RAM_RD_LATENCY-1:0]             sh_valid_r;
  logic [RAM_RD_LATENCY-1:0][OFS_W-1:0]  sh_idx_r;

  assign accept_s      = req_valid && req_ready_r;
  assign last_emerge_s = sh_valid_r[RAM_RD_LATENCY-1] && (sh_idx_r[RAM_RD_LATENCY-1] == LAST_IDX);

  // Next-state and next-strobe logic; cnt_r is the byte index of the access currently on the bus.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    addr_s  = ram_address_r;
    wdata_s = ram_wdata_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cnt_s = {OFS_W{1'b0}};
          if (req_wb) begin
            state_s = WB;
            wr_s    = 1'b1;
            addr_s  = {req_wb_line, {OFS_W{1'b0}}};
            wdata_s = req_wb_data[7:0];
          end else begin
            state_s = RD;
            rd_s    = 1'b1;
            addr_s  = {req_fill_line, {OFS_W{1'b0}}};
          end
        end else begin
          state_s = IDLE;
        end
      end
      WB: begin
        if (cnt_r == LAST_IDX) begin
          state_s = RD;
          cnt_s   = {OFS_W{1'b0}};
          rd_s    = 1'b1;
          addr_s  = {fill_line_r, {OFS_W{1'b0}}};
        end else begin
          cnt_s   = cnt_r + {{(OFS_W-1){1'b0}}, 1'b1};
          wr_s    = 1'b1;
          addr_s  = {wb_line_r, cnt_s};
          wdata_s = wb_data_r[{cnt_s, 3'b000} +: 8];
        end
      end
      RD: begin
        if (cnt_r == LAST_IDX) begin
          state_s = DRAIN;
          cnt_s   = {OFS_W{1'b0}};
        end else begin
          cnt_s   = cnt_r + {{(OFS_W-1){1'b0}}, 1'b1};
          rd_s    = 1'b1;
          addr_s  = {fill_line_r, cnt_s};
        end
      end
      DRAIN: begin
        if (last_emerge_s) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, registered outputs, request capture and read tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= {OFS_W{1'b0}};
      wb_line_r     <= {LINE_W{1'b0}};
      fill_line_r   <= {LINE_W{1'b0}};
      wb_data_r     <= {LINE_BITS{1'b0}};
      fill_data_r   <= {LINE_BITS{1'b0}};
      req_ready_r   <= 1'b1;
      done_r        <= 1'b0;
      ram_rd_r      <= 1'b0;
      ram_wr_r      <= 1'b0;
      ram_address_r <= {ADDRESS_WIDTH{1'b0}};
      ram_wdata_r   <= 8'h00;
      sh_valid_r    <= {RAM_RD_LATENCY{1'b0}};
      sh_idx_r      <= {(RAM_RD_LATENCY*OFS_W){1'b0}};
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      req_ready_r   <= (state_s == IDLE);
      done_r        <= done_s;
      ram_rd_r      <= rd_s;
      ram_wr_r      <= wr_s;
      ram_address_r <= addr_s;
      ram_wdata_r   <= wdata_s;
      if (accept_s) begin
        wb_line_r   <= req_wb_line;
        wb_data_r   <= req_wb_data;
        fill_line_r <= req_fill_line;
      end
      for (int i = 1; i < RAM_RD_LATENCY; i++) begin
        sh_valid_r[i] <= sh_valid_r[i-1];
        sh_idx_r[i]   <= sh_idx_r[i-1];
      end
      sh_valid_r[0] <= ram_rd_r;
      sh_idx_r[0]   <= cnt_r;
      if (sh_valid_r[RAM_RD_LATENCY-1]) begin
        fill_data_r[{sh_idx_r[RAM_RD_LATENCY-1], 3'b000} +: 8] <= ram_rdata;
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign done        = done_r;
  assign fill_data   = fill_data_r;
  assign ram_address = ram_address_r;
  assign ram_rd      = ram_rd_r;
  assign ram_wr      = ram_wr_r;
  assign ram_wdata   = ram_wdata_r;

endmodule

// File: tb/tb_cache_line_mem_engine.sv
// Directed bench: two engines (read latency 2 and 1) on byte RAM models returning addr[7:0]^8'hA5.
module tb_cache_line_mem_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_valid1, req_wb;
  logic [11:0]  req_wb_line, req_fill_line;
  logic [127:0] req_wb_data;
  logic         req_ready, done, ram_rd, ram_wr;
  logic [127:0] fill_data;
  logic [15:0]  ram_address;
  logic [7:0]   ram_wdata, ram_rdata;
  logic         req_ready1, done1, ram_rd1, ram_wr1;
  logic [127:0] fill_data1;
  logic [15:0]  ram_address1;
  logic [7:0]   ram_wdata1, ram_rdata1;

  logic [15:0]  p1_a, p2_a, q1_a;

  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = -1, acc1_cyc = -1, done_cyc = -1, done1_cyc = -1;
  int n_rd = 0, n_wr = 0, n_done = 0, n_done1 = 0, n_both = 0;
  logic [15:0] rd_addr [0:255];
  int          rd_cyc  [0:255];
  logic [15:0] wr_addr [0:255];
  logic [7:0]  wr_data [0:255];
  int          wr_cyc  [0:255];

  cache_line_mem_engine #(.ADDRESS_WIDTH(16), .WORD_OFFSET_WIDTH(2), .RAM_RD_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
    .req_wb_line(req_wb_line), .req_wb_data(req_wb_data), .req_fill_line(req_fill_line),
    .fill_data(fill_data), .done(done), .ram_address(ram_address), .ram_rd(ram_rd),
    .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  cache_line_mem_engine #(.ADDRESS_WIDTH(16), .WORD_OFFSET_WIDTH(2), .RAM_RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_wb(req_wb),
    .req_wb_line(req_wb_line), .req_wb_data(req_wb_data), .req_fill_line(req_fill_line),
    .fill_data(fill_data1), .done(done1), .ram_address(ram_address1), .ram_rd(ram_rd1),
    .ram_wr(ram_wr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1));

  always #5 clk = ~clk;

  // RAM models: data for an address appears exactly latency cycles after the strobe cycle.
  always @(posedge clk) begin
    p1_a <= ram_address;
    p2_a <= p1_a;
    q1_a <= ram_address1;
  end
  assign ram_rdata  = p2_a[7:0] ^ 8'hA5;
  assign ram_rdata1 = q1_a[7:0] ^ 8'hA5;

  // Bus monitor: logs every access with the cycle number it occupied.
  always @(posedge clk) begin
    if (req_valid && req_ready) acc_cyc = cyc;
    if (req_valid1 && req_ready1) acc1_cyc = cyc;
    if (ram_rd) begin rd_addr[n_rd] = ram_address; rd_cyc[n_rd] = cyc; n_rd++; end
    if (ram_wr) begin wr_addr[n_wr] = ram_address; wr_data[n_wr] = ram_wdata; wr_cyc[n_wr] = cyc; n_wr++; end
    if (ram_rd && ram_wr) n_both++;
    if (done) begin done_cyc = cyc; n_done++; end
    if (done1) begin done1_cyc = cyc; n_done1++; end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_fill(input logic [11:0] line);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = {line[3:0], 4'(i)} ^ 8'hA5;
    return r;
  endfunction

  task automatic wait_done(input string tag, input int base, input int limit);
    int k = 0;
    while (n_done == base && k < limit) begin step(); k++; end
    chk(tag, 128'(n_done != base), 128'd1);
  endtask

  task automatic check_reads(input string tag, input int rb, input logic [11:0] line, input int first);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_rd_addr"}, 128'(rd_addr[rb+i]), 128'({line, 4'(i)}));
      chk({tag, "_rd_cyc"}, 128'(rd_cyc[rb+i]), 128'(first + i));
    end
  endtask

  task automatic issue(input logic [11:0] line, input logic wb, input logic [11:0] wline);
    req_fill_line = line;
    req_wb        = wb;
    req_wb_line   = wline;
    req_valid     = 1'b1;
    step();
    req_valid     = 1'b0;
  endtask

  initial begin
    int t, bd, br, bw, k;
    rst = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0; req_wb = 1'b0;
    req_wb_line = 12'h000; req_fill_line = 12'h000; req_wb_data = 128'h0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset values
    chk("rst_ready", 128'(req_ready), 128'd1);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_rd_wr", 128'({ram_rd, ram_wr}), 128'd0);
    chk("rst_addr", 128'(ram_address), 128'h0);
    chk("rst_wdata", 128'(ram_wdata), 128'h0);
    chk("rst_fill", fill_data, 128'h0);
    chk("rst_ready1", 128'(req_ready1), 128'd1);

    // 1: fill only
    bd = n_done; br = n_rd; bw = n_wr;
    issue(12'h012, 1'b0, 12'h000);
    t = acc_cyc;
    wait_done("s1_done_timeout", bd, 40);
    chk("s1_done_cyc", 128'(done_cyc), 128'(t + 19));
    chk("s1_rd_count", 128'(n_rd - br), 128'd16);
    chk("s1_no_wr", 128'(n_wr - bw), 128'd0);
    check_reads("s1", br, 12'h012, t + 1);
    chk("s1_fill", fill_data, exp_fill(12'h012));
    step();
    chk("s1_done_one_cycle", 128'(done), 128'd0);
    chk("s1_ready_after", 128'(req_ready), 128'd1);

    // 2: write-back then fill
    for (int i = 0; i < 16; i++) req_wb_data[8*i +: 8] = 8'(i);
    bd = n_done; br = n_rd; bw = n_wr;
    issue(12'h012, 1'b1, 12'h00A);
    req_wb_data = {16{8'hEE}};
    req_wb_line = 12'h777;
    t = acc_cyc;
    wait_done("s2_done_timeout", bd, 60);
    chk("s2_done_cyc", 128'(done_cyc), 128'(t + 35));
    chk("s2_wr_count", 128'(n_wr - bw), 128'd16);
    for (int i = 0; i < 16; i++) begin
      chk("s2_wr_addr", 128'(wr_addr[bw+i]), 128'(16'h00A0 + 16'(i)));
      chk("s2_wr_data", 128'(wr_data[bw+i]), 128'(i));
      chk("s2_wr_cyc", 128'(wr_cyc[bw+i]), 128'(t + 1 + i));
    end
    check_reads("s2", br, 12'h012, t + 17);
    chk("s2_fill", fill_data, exp_fill(12'h012));

    // 3: back-to-back requests with req_valid held high
    step();
    bd = n_done; br = n_rd;
    req_wb = 1'b0; req_fill_line = 12'h012; req_valid = 1'b1;
    step();
    t = acc_cyc;
    req_fill_line = 12'h056;
    for (int kk = 1; kk <= 19; kk++) begin
      chk("s3_ready_low", 128'(req_ready), 128'd0);
      if (kk < 19) step();
    end
    chk("s3_done_at_T19", 128'(done), 128'd1);
    step();
    chk("s3_ready_back", 128'(req_ready), 128'd1);
    step();
    req_valid = 1'b0;
    chk("s3_second_acc", 128'(acc_cyc), 128'(t + 20));
    chk("s3_one_done", 128'(n_done - bd), 128'd1);
    check_reads("s3a", br, 12'h012, t + 1);
    wait_done("s3b_done_timeout", bd + 1, 40);
    chk("s3b_done_cyc", 128'(done_cyc), 128'(t + 39));
    check_reads("s3b", br + 16, 12'h056, t + 21);
    chk("s3b_fill", fill_data, exp_fill(12'h056));
    step();
    chk("s3_two_done", 128'(n_done - bd), 128'd2);

    // 4: reset during the 5th read strobe
    bd = n_done;
    issue(12'h034, 1'b0, 12'h000);
    k = 0;
    while (!(ram_rd && ram_address[3:0] == 4'h4) && k < 20) begin step(); k++; end
    chk("s4_reach_5th_rd", 128'(ram_rd && ram_address == 16'h0344), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s4_rd_cleared", 128'(ram_rd), 128'd0);
    chk("s4_ready", 128'(req_ready), 128'd1);
    chk("s4_done_low", 128'(done), 128'd0);
    chk("s4_fill_cleared", fill_data, 128'h0);
    br = n_rd;
    repeat (12) step();
    chk("s4_no_done", 128'(n_done - bd), 128'd0);
    chk("s4_no_reads", 128'(n_rd - br), 128'd0);
    issue(12'h012, 1'b0, 12'h000);
    t = acc_cyc;
    wait_done("s4_done_timeout", bd, 40);
    chk("s4_done_cyc", 128'(done_cyc), 128'(t + 19));
    check_reads("s4", br, 12'h012, t + 1);
    chk("s4_fill", fill_data, exp_fill(12'h012));

    // 5: top line, no wrap
    step();
    bd = n_done; br = n_rd;
    issue(12'hFFF, 1'b0, 12'h000);
    t = acc_cyc;
    wait_done("s5_done_timeout", bd, 40);
    chk("s5_rd_count", 128'(n_rd - br), 128'd16);
    check_reads("s5", br, 12'hFFF, t + 1);
    chk("s5_fill", fill_data, exp_fill(12'hFFF));

    // 6: read latency 1 instance
    bd = n_done1;
    req_fill_line = 12'h012; req_wb = 1'b0; req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    t = acc1_cyc;
    k = 0;
    while (n_done1 == bd && k < 40) begin step(); k++; end
    chk("s6_done_seen", 128'(n_done1 - bd), 128'd1);
    chk("s6_done_cyc", 128'(done1_cyc), 128'(t + 18));
    chk("s6_fill", fill_data1, exp_fill(12'h012));

    chk("never_rd_and_wr", 128'(n_both), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
